// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB75 LED panel scan driver.
// Reads a synchronous framebuffer one row pair at a time, shifts the colour
// bits out with a generated panel clock, latches them and shows each bit
// plane for BASE_TICKS<<plane clocks (binary-coded modulation).
//
// Optional feature (macro LEDMATRIX_BUF_SWAP_EN): double-buffered framebuffer.
// Adds SwapReq (in) / Bank (out); Bank becomes the RdAddr MSB and only
// changes on the FrameDone clock, so a frame never mixes banks.
//
// Ports:
//   Clk, Rst_n          clock, synchronous active-low reset
//   Enable              run scanning (sampled in IDLE and at row/plane end)
//   RdAddr / RdData     framebuffer address {[bank,] row, col} / colour word
//                       {R1,G1,B1,R2,G2,B2}, captured one clock after RdAddr
//   R1..B2              panel colour bits (upper / lower half)
//   PanelClk, Lat, OE_n panel shift clock, latch, output enable (active low)
//   Addr                panel row address
//   FrameDone           one-clock pulse when the row counter wraps
//   Busy                FSM not in IDLE
module hub75_scan_driver #(
    parameter int unsigned COLS       = 32,
    parameter int unsigned ADDR_BITS  = 3,
    parameter int unsigned BPC        = 4,
    parameter int unsigned BASE_TICKS = 8,
    localparam int unsigned CW        = $clog2(COLS),
`ifdef LEDMATRIX_BUF_SWAP_EN
    localparam int unsigned RAW       = ADDR_BITS + CW + 1
`else
    localparam int unsigned RAW       = ADDR_BITS + CW
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Enable,
`ifdef LEDMATRIX_BUF_SWAP_EN
    input  logic                 SwapReq,
    output logic                 Bank,
`endif
    output logic [RAW-1:0]       RdAddr,
    input  logic [6*BPC-1:0]     RdData,
    output logic                 R1,
    output logic                 G1,
    output logic                 B1,
    output logic                 R2,
    output logic                 G2,
    output logic                 B2,
    output logic                 PanelClk,
    output logic                 Lat,
    output logic                 OE_n,
    output logic [ADDR_BITS-1:0] Addr,
    output logic                 FrameDone,
    output logic                 Busy
);

    localparam int unsigned SW  = CW + 2;
    localparam int unsigned PW  = $clog2(BPC) + 1;
    localparam int unsigned DCW = $clog2(BASE_TICKS << (BPC - 1)) + 1;

    localparam logic [SW-1:0]  LAST_STEP  = SW'(2 * COLS);
    localparam logic [PW-1:0]  LAST_PLANE = PW'(BPC - 1);
    localparam logic [DCW-1:0] BASE_D     = DCW'(BASE_TICKS);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        step_q, step_d;
    logic [PW-1:0]        plane_q, plane_d;
    logic [ADDR_BITS-1:0] row_q, row_d;
    logic [DCW-1:0]       disp_q, disp_d;
    logic [5:0]           rgb_q, rgb_d;
    logic                 pclk_q, pclk_d;
    logic                 lat_q, lat_d;
    logic                 oe_n_q, oe_n_d;
    logic                 fd_q, fd_d;
    logic                 busy_q, busy_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [RAW-1:0]       rdaddr_q, rdaddr_d;
    logic [CW-1:0]        col_d;
`ifdef LEDMATRIX_BUF_SWAP_EN
    logic                 bank_q, bank_d;
    logic                 pend_q, pend_d;
`endif

    // Current bit plane of each colour field; bit 5 = R1 ... bit 0 = B2
    logic [5:0][BPC-1:0] fields;
    logic [5:0]          plane_bits;

    assign fields = RdData;

    for (genvar g = 0; g < 6; g++) begin : g_plane
        assign plane_bits[g] = 1'(fields[g] >> plane_q);
    end

    // Next-state and next-output logic; outputs are registered from next state
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        plane_d  = plane_q;
        row_d    = row_q;
        disp_d   = disp_q;
        rgb_d    = rgb_q;
        addr_d   = addr_q;
        rdaddr_d = rdaddr_q;
        pclk_d   = 1'b0;
        lat_d    = 1'b0;
        oe_n_d   = 1'b1;
        fd_d     = 1'b0;
        busy_d   = 1'b0;
        col_d    = '0;
`ifdef LEDMATRIX_BUF_SWAP_EN
        bank_d   = bank_q;
        pend_d   = pend_q | SwapReq;
`endif

        unique case (state_q)
            IDLE: begin
                if (Enable) begin
                    state_d = SHIFT;
                    step_d  = '0;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            SHIFT: begin
                if (step_q == LAST_STEP) begin
                    state_d = LATCH;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            LATCH: begin
                state_d = DISPLAY;
                disp_d  = (BASE_D << plane_q) - DCW'(1);
            end
            DISPLAY: begin
                if (disp_q != '0) begin
                    disp_d = disp_q - DCW'(1);
                end else begin
                    step_d = '0;
                    if (plane_q < LAST_PLANE) begin
                        plane_d = plane_q + PW'(1);
                        state_d = SHIFT;
                    end else begin
                        plane_d = '0;
                        row_d   = row_q + ADDR_BITS'(1);
                        fd_d    = (row_q == '1);
                        state_d = Enable ? SHIFT : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef LEDMATRIX_BUF_SWAP_EN
        // Bank only flips at the frame boundary so a frame reads one bank
        if (fd_d && pend_d) begin
            bank_d = ~bank_q;
            pend_d = 1'b0;
        end
`endif

        // Step 0 primes column 0; odd steps prefetch the next column
        col_d  = CW'((step_d + SW'(1)) >> 1);
        busy_d = (state_d != IDLE);

        unique case (state_d)
            SHIFT: begin
                pclk_d = (step_d != '0) && !step_d[0];
`ifdef LEDMATRIX_BUF_SWAP_EN
                rdaddr_d = {bank_d, row_d, col_d};
`else
                rdaddr_d = {row_d, col_d};
`endif
                // Load on entering phase0; held through phase1 rising PanelClk
                if (step_d[0]) begin
                    rgb_d = plane_bits;
                end
            end
            LATCH: begin
                lat_d  = 1'b1;
                addr_d = row_d;
            end
            DISPLAY: oe_n_d = 1'b0;
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            plane_q  <= '0;
            row_q    <= '0;
            disp_q   <= '0;
            rgb_q    <= '0;
            pclk_q   <= 1'b0;
            lat_q    <= 1'b0;
            oe_n_q   <= 1'b1;
            fd_q     <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            rdaddr_q <= '0;
`ifdef LEDMATRIX_BUF_SWAP_EN
            bank_q   <= 1'b0;
            pend_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            plane_q  <= plane_d;
            row_q    <= row_d;
            disp_q   <= disp_d;
            rgb_q    <= rgb_d;
            pclk_q   <= pclk_d;
            lat_q    <= lat_d;
            oe_n_q   <= oe_n_d;
            fd_q     <= fd_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            rdaddr_q <= rdaddr_d;
`ifdef LEDMATRIX_BUF_SWAP_EN
            bank_q   <= bank_d;
            pend_q   <= pend_d;
`endif
        end
    end

    assign {R1, G1, B1, R2, G2, B2} = rgb_q;
    assign PanelClk  = pclk_q;
    assign Lat       = lat_q;
    assign OE_n      = oe_n_q;
    assign Addr      = addr_q;
    assign RdAddr    = rdaddr_q;
    assign FrameDone = fd_q;
    assign Busy      = busy_q;
`ifdef LEDMATRIX_BUF_SWAP_EN
    assign Bank      = bank_q;
`endif

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Testbench for hub75_scan_driver (COLS=4, ADDR_BITS=1, BPC=2, BASE_TICKS=2).
// Framebuffer modelled as RdData = f(RdAddr); expected panel activity is
// generated per row from the scan schedule into a scoreboard queue.
module tb_hub75_scan_driver;

    localparam int unsigned COLS       = 4;
    localparam int unsigned ADDR_BITS  = 1;
    localparam int unsigned BPC        = 2;
    localparam int unsigned BASE_TICKS = 2;
    localparam int unsigned CW         = $clog2(COLS);
`ifdef LEDMATRIX_BUF_SWAP_EN
    localparam int unsigned RAW        = ADDR_BITS + CW + 1;
`else
    localparam int unsigned RAW        = ADDR_BITS + CW;
`endif
    localparam int unsigned DW         = 6 * BPC;
    // Row period 2*(2*4+2) + 2 + 4 = 26 clocks, two rows per frame
    localparam int          ROW_CLKS   = 26;
    localparam int          FRAME_CLKS = 52;

    localparam logic [DW-1:0] PAT = {{BPC{1'b1}}, {BPC{1'b0}}, {BPC{1'b1}},
                                     {BPC{1'b0}}, {BPC{1'b1}}, {BPC{1'b0}}};

    typedef struct packed {
        logic                 fd;
        logic                 busy;
        logic                 oe_n;
        logic                 lat;
        logic                 pclk;
        logic [ADDR_BITS-1:0] addr;
        logic [RAW-1:0]       rdaddr;
        logic [5:0]           rgb;
    } exp_t;

    typedef struct {
        logic  rst_n;
        logic  en;
        exp_t  exp;
        string name;
    } vec_t;

    logic                 Clk;
    logic                 Rst_n;
    logic                 Enable;
    logic [RAW-1:0]       RdAddr;
    logic [DW-1:0]        RdData;
    logic                 R1, G1, B1, R2, G2, B2;
    logic                 PanelClk, Lat, OE_n;
    logic [ADDR_BITS-1:0] Addr;
    logic                 FrameDone, Busy;
`ifdef LEDMATRIX_BUF_SWAP_EN
    logic                 SwapReq;
    logic                 Bank;
`endif

    logic       const_mode;
    logic [5:0] cur_rgb;
    logic [ADDR_BITS-1:0] cur_addr;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    hub75_scan_driver #(
        .COLS(COLS), .ADDR_BITS(ADDR_BITS), .BPC(BPC), .BASE_TICKS(BASE_TICKS)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
`ifdef LEDMATRIX_BUF_SWAP_EN
        .SwapReq(SwapReq), .Bank(Bank),
`endif
        .RdAddr(RdAddr), .RdData(RdData),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .PanelClk(PanelClk), .Lat(Lat), .OE_n(OE_n), .Addr(Addr),
        .FrameDone(FrameDone), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] hash_f(input logic [RAW-1:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        return DW'(x);
    endfunction

    // Framebuffer: data valid while its address is presented
    always_comb RdData = const_mode ? PAT : hash_f(RdAddr);

    function automatic logic [RAW-1:0] mk_addr(input int row, input int col);
        return RAW'((row << CW) | col);
    endfunction

    function automatic logic [DW-1:0] data_at(input int row, input int col);
        return const_mode ? PAT : hash_f(mk_addr(row, col));
    endfunction

    // Bit p of each field, packed R1..B2 from MSB to LSB
    function automatic logic [5:0] plane_of(input logic [DW-1:0] d, input int p);
        logic [5:0]    r;
        logic [DW-1:0] t;
        r = '0;
        for (int k = 5; k >= 0; k--) begin
            t = d >> (k * BPC + p);
            r = {r[4:0], t[0]};
        end
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic fd, input logic busy, input logic oe_n,
                                    input logic lat, input logic pclk,
                                    input logic [ADDR_BITS-1:0] addr,
                                    input logic [RAW-1:0] rdaddr, input logic [5:0] rgb);
        exp_t e;
        e.fd = fd; e.busy = busy; e.oe_n = oe_n; e.lat = lat; e.pclk = pclk;
        e.addr = addr; e.rdaddr = rdaddr; e.rgb = rgb;
        return e;
    endfunction

    function automatic exp_t sample();
        return mk_exp(FrameDone, Busy, OE_n, Lat, PanelClk, Addr, RdAddr,
                      {R1, G1, B1, R2, G2, B2});
    endfunction

    task automatic check_exp(input exp_t e, input string name);
        exp_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got fd=%b busy=%b oe_n=%b lat=%b pclk=%b addr=%0d rdaddr=%0d rgb=%b want fd=%b busy=%b oe_n=%b lat=%b pclk=%b addr=%0d rdaddr=%0d rgb=%b",
                     name, a.fd, a.busy, a.oe_n, a.lat, a.pclk, a.addr, a.rdaddr, a.rgb,
                     e.fd, e.busy, e.oe_n, e.lat, e.pclk, e.addr, e.rdaddr, e.rgb);
        end
    endtask

    task automatic check_bit(input logic act, input logic want, input string name);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, want);
        end
    endtask

    // Expected per-clock activity for one full row (all planes)
    task automatic push_row(input int row, input logic fd_first);
        exp_t e;
        for (int p = 0; p < BPC; p++) begin
            for (int s = 0; s <= 2 * COLS; s++) begin
                if (s % 2 == 1) cur_rgb = plane_of(data_at(row, (s - 1) / 2), p);
                e = mk_exp((p == 0 && s == 0) ? fd_first : 1'b0, 1'b1, 1'b1, 1'b0,
                           (s > 0 && s % 2 == 0), cur_addr,
                           mk_addr(row, ((s + 1) / 2) % COLS), cur_rgb);
                sb.push_back(e);
            end
            cur_addr = ADDR_BITS'(row);
            sb.push_back(mk_exp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, cur_addr, mk_addr(row, 0), cur_rgb));
            for (int t = 0; t < (int'(BASE_TICKS) << p); t++)
                sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cur_addr, mk_addr(row, 0), cur_rgb));
        end
    endtask

    task automatic push_idle(input int n, input logic [RAW-1:0] rdaddr);
        for (int i = 0; i < n; i++)
            sb.push_back(mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cur_addr, rdaddr, cur_rgb));
    endtask

    initial begin : main
        vec_t tbl[8];
        exp_t rst_e;
        exp_t e;
        int   n;
        int   fd_idx[$];
        int   diff;

        rst_e = mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 6'b0);
        tbl[0] = '{1'b0, 1'b0, rst_e, "rst_hold"};
        tbl[1] = '{1'b0, 1'b1, rst_e, "rst_hold_en"};
        tbl[2] = '{1'b1, 1'b0, rst_e, "idle_en0_a"};
        tbl[3] = '{1'b1, 1'b0, rst_e, "idle_en0_b"};
        tbl[4] = '{1'b1, 1'b1, mk_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, mk_addr(0, 0), 6'b0), "shift_prime"};
        tbl[5] = '{1'b1, 1'b0, mk_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, mk_addr(0, 1), 6'b101010), "shift_c0_ph0"};
        tbl[6] = '{1'b1, 1'b0, mk_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0, mk_addr(0, 1), 6'b101010), "shift_c0_ph1"};
        tbl[7] = '{1'b0, 1'b0, rst_e, "rst_in_shift"};

        const_mode = 1'b1;
        Rst_n  = 1'b0;
        Enable = 1'b0;
`ifdef LEDMATRIX_BUF_SWAP_EN
        SwapReq = 1'b0;
`endif

        // Reset / idle / first shift clocks
        for (int i = 0; i < 8; i++) begin
            Rst_n  = tbl[i].rst_n;
            Enable = tbl[i].en;
            @(posedge Clk);
            @(negedge Clk);
            check_exp(tbl[i].exp, tbl[i].name);
        end

        // Constant pattern through rows 0,1 then reset at column 2 of the next row 0
        cur_rgb  = '0;
        cur_addr = '0;
        sb.delete();
        push_row(0, 1'b0);
        push_row(1, 1'b0);
        push_row(0, 1'b1);
        Rst_n  = 1'b1;
        Enable = 1'b1;
        for (int i = 0; i < FRAME_CLKS + 6; i++) begin
            @(negedge Clk);
            e = sb.pop_front();
            check_exp(e, $sformatf("const[%0d]", i));
        end
        Rst_n = 1'b0;
        @(negedge Clk);
        check_exp(rst_e, "rst_mid_col2");
        sb.delete();

        // Hashed framebuffer, two frames, Enable dropped in plane 0 display of row 4
        const_mode = 1'b0;
        Enable = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_exp(rst_e, "idle_after_rst");
        cur_rgb  = '0;
        cur_addr = '0;
        push_row(0, 1'b0);
        push_row(1, 1'b0);
        push_row(0, 1'b1);
        push_row(1, 1'b0);
        push_row(0, 1'b1);
        push_idle(3, mk_addr(0, 0));
        n = sb.size();
        Enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            e = sb.pop_front();
            check_exp(e, $sformatf("scan[%0d]", i));
            if (FrameDone === 1'b1) fd_idx.push_back(i);
            if (i == 4 * ROW_CLKS + 10) Enable = 1'b0;
        end
        diff = (fd_idx.size() == 2) ? fd_idx[1] - fd_idx[0] : -1;
        checks++;
        if (diff != FRAME_CLKS) begin
            errors++;
            $display("FAIL frame_period got %0d pulses spacing %0d want 2 pulses spacing %0d",
                     fd_idx.size(), diff, FRAME_CLKS);
        end

`ifdef LEDMATRIX_BUF_SWAP_EN
        // SwapReq pulse mid-frame: Bank flips on the next FrameDone clock only
        begin : swap_test
            logic found;
            logic prev_bank;
            Enable = 1'b1;
            repeat (20) @(negedge Clk);
            SwapReq = 1'b1;
            @(negedge Clk);
            SwapReq = 1'b0;
            check_bit(Bank, 1'b0, "bank_before_fd");
            found = 1'b0;
            prev_bank = Bank;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge Clk);
                if (FrameDone === 1'b1) found = 1'b1;
                else prev_bank = Bank;
            end
            check_bit(found, 1'b1, "fd_seen");
            check_bit(prev_bank, 1'b0, "bank_pre_fd_clk");
            check_bit(Bank, 1'b1, "bank_at_fd");
            check_bit(RdAddr[RAW-1], 1'b1, "rdaddr_bank_msb");
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge Clk);
                if (FrameDone === 1'b1) found = 1'b1;
            end
            check_bit(found, 1'b1, "fd2_seen");
            check_bit(Bank, 1'b1, "bank_no_req_hold");
            Enable = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
